// File: rtl/multicycle_sequencer_if.sv
// Shared memory-port handshake between the multi-cycle sequencer (master) and memory (slave).
interface multicycle_sequencer_if;
    logic mem_req;
    logic mem_wr;
    logic addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_wr, output addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_wr, input addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I core over one shared memory port.
// Define SEQ_MEM_TIMEOUT_EN to trap a memory request left unanswered for TIMEOUT_CYCLES cycles.
module multicycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int INSTRET_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_sequencer_if.master mem,
    input  logic [6:0]             opcode,
    input  logic                   br_taken,
    output logic                   ir_le,
    output logic                   pc_le,
    output logic                   pc_sel,
    output logic                   rf_we,
    output logic [2:0]             state,
    output logic [INSTRET_W-1:0]   instret,
    output logic                   err,
    output logic [1:0]             err_code
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_LOADS    = 7'b0000011;
    localparam logic [6:0] OP_STORES   = 7'b0100011;
    localparam logic [6:0] OP_BTYPE    = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_ARITHM_I = 7'b0010011;
    localparam logic [6:0] OP_ARITHM_R = 7'b0110011;

    state_t cur;
    logic   is_load;
    logic   is_store;
    logic   is_btype;
    logic   is_jump;
    logic   is_wb_op;
    logic   timeout;

    assign is_load  = (opcode == OP_LOADS);
    assign is_store = (opcode == OP_STORES);
    assign is_btype = (opcode == OP_BTYPE);
    assign is_jump  = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign is_wb_op = (opcode == OP_LUI) || (opcode == OP_AUIPC) || is_jump ||
                      (opcode == OP_ARITHM_I) || (opcode == OP_ARITHM_R);

    assign state = cur;
    assign err   = (err_code != 2'b00);

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [CNT_W-1:0] wait_cnt;

    // A ready in the final wait cycle still wins, so the timeout only fires on a genuine miss.
    assign timeout = mem.mem_req && !mem.mem_ready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!mem.mem_req || mem.mem_ready) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Strobes depend on live OPCODE/BR_TAKEN/MEM_READY so the retire happens in the same cycle.
    always_comb begin
        mem.mem_req  = 1'b0;
        mem.mem_wr   = 1'b0;
        mem.addr_sel = 1'b0;
        ir_le        = 1'b0;
        pc_le        = 1'b0;
        pc_sel       = 1'b0;
        rf_we        = 1'b0;
        case (cur)
            FETCH: begin
                mem.mem_req = 1'b1;
                ir_le       = mem.mem_ready;
            end
            EXEC: begin
                if (is_btype) begin
                    pc_le  = 1'b1;
                    pc_sel = br_taken;
                end
            end
            MEM: begin
                mem.mem_req  = 1'b1;
                mem.addr_sel = 1'b1;
                mem.mem_wr   = is_store;
                pc_le        = mem.mem_ready && is_store;
            end
            WB: begin
                rf_we  = 1'b1;
                pc_le  = 1'b1;
                pc_sel = is_jump;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= IDLE;
            instret  <= '0;
            err_code <= 2'b00;
        end else begin
            if (pc_le) begin
                instret <= instret + 1'b1;
            end
            case (cur)
                IDLE:   cur <= FETCH;
                FETCH: begin
                    if (mem.mem_ready) begin
                        cur <= DECODE;
                    end else if (timeout) begin
                        cur      <= TRAP;
                        err_code <= 2'b10;
                    end
                end
                DECODE: cur <= EXEC;
                EXEC: begin
                    if (is_load || is_store) begin
                        cur <= MEM;
                    end else if (is_btype) begin
                        cur <= FETCH;
                    end else if (is_wb_op) begin
                        cur <= WB;
                    end else begin
                        cur      <= TRAP;
                        err_code <= 2'b01;
                    end
                end
                MEM: begin
                    if (mem.mem_ready) begin
                        cur <= is_store ? FETCH : WB;
                    end else if (timeout) begin
                        cur      <= TRAP;
                        err_code <= 2'b10;
                    end
                end
                WB:     cur <= FETCH;
                TRAP:   cur <= TRAP;
                default: cur <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-cycle vector table plus hand-written reset/trap/timeout sequences.
module tb_multicycle_sequencer;

    localparam int INSTRET_W      = 3;
    localparam int TIMEOUT_CYCLES = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    // Strobe order: mem_req mem_wr addr_sel ir_le pc_le pc_sel rf_we err
    localparam logic [7:0] S_NONE        = 8'b0000_0000;
    localparam logic [7:0] S_FETCH_WAIT  = 8'b1000_0000;
    localparam logic [7:0] S_FETCH_RDY   = 8'b1001_0000;
    localparam logic [7:0] S_MEM_RD      = 8'b1010_0000;
    localparam logic [7:0] S_MEM_WR_DONE = 8'b1110_1000;
    localparam logic [7:0] S_WB          = 8'b0000_1010;
    localparam logic [7:0] S_WB_JMP      = 8'b0000_1110;
    localparam logic [7:0] S_BR_T        = 8'b0000_1100;
    localparam logic [7:0] S_BR_NT       = 8'b0000_1000;
    localparam logic [7:0] S_TRAP        = 8'b0000_0001;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [6:0]           opcode;
    logic                 br_taken;
    logic                 ir_le, pc_le, pc_sel, rf_we, err;
    logic [2:0]           state;
    logic [INSTRET_W-1:0] instret;
    logic [1:0]           err_code;

    multicycle_sequencer_if mem_if ();

    multicycle_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .INSTRET_W     (INSTRET_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem     (mem_if),
        .opcode  (opcode),
        .br_taken(br_taken),
        .ir_le   (ir_le),
        .pc_le   (pc_le),
        .pc_sel  (pc_sel),
        .rf_we   (rf_we),
        .state   (state),
        .instret (instret),
        .err     (err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]           st;
        logic [7:0]           strb;
        logic [1:0]           code;
        logic [INSTRET_W-1:0] ret;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic       br;
        logic       rdy;
        out_t       exp;
    } vec_t;

    vec_t                 vecs[$];
    out_t                 exp_q[$];
    logic [INSTRET_W-1:0] model_ret;
    int                   checks = 0;
    int                   passes = 0;

    function automatic vec_t mk(input logic [6:0] op, input logic br, input logic rdy,
                                input logic [2:0] st, input logic [7:0] strb, input logic [1:0] code);
        vec_t v;
        v.op       = op;
        v.br       = br;
        v.rdy      = rdy;
        v.exp.st   = st;
        v.exp.strb = strb;
        v.exp.code = code;
        v.exp.ret  = '0;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Drive one cycle's inputs and queue the expected outputs; instret is modelled here.
    task automatic applyStimulus(input vec_t v);
        out_t e;
        opcode           = v.op;
        br_taken         = v.br;
        mem_if.mem_ready = v.rdy;
        e                = v.exp;
        e.ret            = model_ret;
        exp_q.push_back(e);
        if (e.strb[3]) model_ret = model_ret + 1'b1;
    endtask

    task automatic checkOutput(input string name);
        out_t act;
        out_t e;
        @(negedge clk);
        act = {state, mem_if.mem_req, mem_if.mem_wr, mem_if.addr_sel, ir_le, pc_le, pc_sel,
               rf_we, err, err_code, instret};
        checks++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL %s: scoreboard empty, got %b", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act === e) passes++;
            else $display("[TB] FAIL %s: got st=%0d strb=%b code=%b ret=%0d, expected st=%0d strb=%b code=%b ret=%0d",
                          name, act.st, act.strb, act.code, act.ret, e.st, e.strb, e.code, e.ret);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        applyStimulus(v);
        checkOutput(name);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        model_ret = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n            = 1'b0;
        opcode           = '0;
        br_taken         = 1'b0;
        mem_if.mem_ready = 1'b0;
        model_ret        = '0;

        // ADDI, LW with 3 waits, SW, BEQ taken/not, JAL, LUI after fetch waits, ADDI wrapping instret
        vecs.push_back(mk(OP_ADDI,   0, 1, 0, S_NONE,        2'b00));
        vecs.push_back(mk(OP_ADDI,   0, 1, 1, S_FETCH_RDY,   2'b00));
        vecs.push_back(mk(OP_ADDI,   0, 1, 2, S_NONE,        2'b00));
        vecs.push_back(mk(OP_ADDI,   0, 1, 3, S_NONE,        2'b00));
        vecs.push_back(mk(OP_ADDI,   0, 1, 5, S_WB,          2'b00));
        vecs.push_back(mk(OP_LOAD,   0, 1, 1, S_FETCH_RDY,   2'b00));
        vecs.push_back(mk(OP_LOAD,   0, 1, 2, S_NONE,        2'b00));
        vecs.push_back(mk(OP_LOAD,   0, 0, 3, S_NONE,        2'b00));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(OP_LOAD, 0, 0, 4, S_MEM_RD, 2'b00));
        vecs.push_back(mk(OP_LOAD,   0, 1, 4, S_MEM_RD,      2'b00));
        vecs.push_back(mk(OP_LOAD,   0, 0, 5, S_WB,          2'b00));
        vecs.push_back(mk(OP_STORE,  0, 1, 1, S_FETCH_RDY,   2'b00));
        vecs.push_back(mk(OP_STORE,  0, 1, 2, S_NONE,        2'b00));
        vecs.push_back(mk(OP_STORE,  0, 1, 3, S_NONE,        2'b00));
        vecs.push_back(mk(OP_STORE,  0, 1, 4, S_MEM_WR_DONE, 2'b00));
        vecs.push_back(mk(OP_BRANCH, 1, 1, 1, S_FETCH_RDY,   2'b00));
        vecs.push_back(mk(OP_BRANCH, 1, 1, 2, S_NONE,        2'b00));
        vecs.push_back(mk(OP_BRANCH, 1, 1, 3, S_BR_T,        2'b00));
        vecs.push_back(mk(OP_BRANCH, 0, 1, 1, S_FETCH_RDY,   2'b00));
        vecs.push_back(mk(OP_BRANCH, 0, 1, 2, S_NONE,        2'b00));
        vecs.push_back(mk(OP_BRANCH, 0, 1, 3, S_BR_NT,       2'b00));
        vecs.push_back(mk(OP_JAL,    1, 1, 1, S_FETCH_RDY,   2'b00));
        vecs.push_back(mk(OP_JAL,    1, 1, 2, S_NONE,        2'b00));
        vecs.push_back(mk(OP_JAL,    1, 1, 3, S_NONE,        2'b00));
        vecs.push_back(mk(OP_JAL,    0, 1, 5, S_WB_JMP,      2'b00));
        vecs.push_back(mk(OP_LUI,    0, 0, 1, S_FETCH_WAIT,  2'b00));
        vecs.push_back(mk(OP_LUI,    0, 0, 1, S_FETCH_WAIT,  2'b00));
        vecs.push_back(mk(OP_LUI,    0, 1, 1, S_FETCH_RDY,   2'b00));
        vecs.push_back(mk(OP_LUI,    0, 1, 2, S_NONE,        2'b00));
        vecs.push_back(mk(OP_LUI,    0, 1, 3, S_NONE,        2'b00));
        vecs.push_back(mk(OP_LUI,    0, 1, 5, S_WB,          2'b00));
        vecs.push_back(mk(OP_ADDI,   0, 1, 1, S_FETCH_RDY,   2'b00));
        vecs.push_back(mk(OP_ADDI,   0, 1, 2, S_NONE,        2'b00));
        vecs.push_back(mk(OP_ADDI,   0, 1, 3, S_NONE,        2'b00));
        vecs.push_back(mk(OP_ADDI,   0, 1, 5, S_WB,          2'b00));
        vecs.push_back(mk(OP_ADDI,   0, 0, 1, S_FETCH_WAIT,  2'b00));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec[%0d]", i));

        // Illegal opcode traps in EXEC and stays put until reset.
        do_reset();
        run_vec(mk(OP_BAD, 0, 1, 0, S_NONE,      2'b00), "bad idle");
        run_vec(mk(OP_BAD, 0, 1, 1, S_FETCH_RDY, 2'b00), "bad fetch");
        run_vec(mk(OP_BAD, 0, 1, 2, S_NONE,      2'b00), "bad decode");
        run_vec(mk(OP_BAD, 0, 1, 3, S_NONE,      2'b00), "bad exec");
        for (int i = 0; i < 20; i++) run_vec(mk(OP_BAD, 0, 1, 6, S_TRAP, 2'b01), $sformatf("trap[%0d]", i));
        rst_n = 1'b0;
        #1;
        check_val("trap reset state", 32'(state), 32'd0);
        check_val("trap reset err", 32'(err), 32'd0);
        check_val("trap reset code", 32'(err_code), 32'd0);

        // Asynchronous reset in the middle of a load request.
        do_reset();
        run_vec(mk(OP_LOAD, 0, 1, 0, S_NONE,      2'b00), "rst idle");
        run_vec(mk(OP_LOAD, 0, 1, 1, S_FETCH_RDY, 2'b00), "rst fetch");
        run_vec(mk(OP_LOAD, 0, 1, 2, S_NONE,      2'b00), "rst decode");
        run_vec(mk(OP_LOAD, 0, 0, 3, S_NONE,      2'b00), "rst exec");
        applyStimulus(mk(OP_LOAD, 0, 0, 4, S_MEM_RD, 2'b00));
        checkOutput("rst mem");
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async mem_req", 32'(mem_if.mem_req), 32'd0);
        check_val("async addr_sel", 32'(mem_if.addr_sel), 32'd0);
        check_val("async state", 32'(state), 32'd0);
        model_ret = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vec(mk(OP_LOAD, 0, 0, 0, S_NONE,       2'b00), "post-rst idle");
        run_vec(mk(OP_LOAD, 0, 0, 1, S_FETCH_WAIT, 2'b00), "post-rst fetch");

        // Fetch never answered: traps with code 10 only when the timeout is built in.
        do_reset();
        run_vec(mk(OP_LOAD, 0, 0, 0, S_NONE, 2'b00), "to idle");
`ifdef SEQ_MEM_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT_CYCLES; i++) run_vec(mk(OP_LOAD, 0, 0, 1, S_FETCH_WAIT, 2'b00), $sformatf("to wait[%0d]", i));
        for (int i = 0; i < 3; i++) run_vec(mk(OP_LOAD, 0, 1, 6, S_TRAP, 2'b10), $sformatf("to trap[%0d]", i));
`else
        for (int i = 0; i < 10; i++) run_vec(mk(OP_LOAD, 0, 0, 1, S_FETCH_WAIT, 2'b00), $sformatf("to wait[%0d]", i));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
